// File: rtl/air_spi_responder.sv
// SPI mode-0 responder giving an external host read/write access to an
// 8-bit register bank. All SPI pins are oversampled in the clock_sig domain.
// Frame layout: command byte, ADDR_BYTES address bytes (MSB byte first),
// then any number of data bytes. 0x02 writes, 0x03 reads, anything else is
// ignored until chip select is released.
module air_spi_responder #(
    parameter int ADDR_BYTES = 1
) (
    input  logic                    clock_sig,
    input  logic                    reset_sig,
    input  logic                    spi_ss_n,
    input  logic                    spi_sclk,
    input  logic                    spi_mosi,
    output logic                    spi_miso,
    output logic                    spi_miso_oe,
    output logic [8*ADDR_BYTES-1:0] reg_address,
    output logic                    reg_write,
    output logic [7:0]              reg_writedata,
    output logic                    reg_read,
    input  logic [7:0]              reg_readdata,
    output logic                    busy
);

    localparam int AW = 8 * ADDR_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_WDATA,
        ST_RDATA,
        ST_IGNORE,
        ST_WAIT_DESEL
    } state_t;

    state_t state;

    logic ss_meta, ss_sync, ss_prev;
    logic sclk_meta, sclk_sync, sclk_prev;
    logic mosi_meta, mosi_sync;

    logic [2:0]    bit_cnt;
    logic [6:0]    rx_shift;
    logic [7:0]    tx_shift;
    logic [1:0]    addr_cnt;
    logic          is_read;
    logic          load_pending;

    logic          rise;
    logic          fall;
    logic          byte_done;
    logic [7:0]    rx_next;
    logic [AW-1:0] addr_next;

    // Synchronisers are left free-running through reset so that chip select
    // seen at reset release reflects the real pin and a frame already in
    // flight is not mistaken for a fresh select.
    always_ff @(posedge clock_sig) begin
        ss_meta   <= spi_ss_n;
        ss_sync   <= ss_meta;
        sclk_meta <= spi_sclk;
        sclk_sync <= sclk_meta;
        sclk_prev <= sclk_sync;
        mosi_meta <= spi_mosi;
        mosi_sync <= mosi_meta;
    end

    assign rise      = sclk_sync & ~sclk_prev;
    assign fall      = ~sclk_sync & sclk_prev;
    assign rx_next   = {rx_shift, mosi_sync};
    assign byte_done = rise && (bit_cnt == 3'd7);

    // The incoming address byte is appended below the bytes already received.
    generate
        if (ADDR_BYTES == 1) begin : g_addr1
            assign addr_next = rx_next;
        end else begin : g_addrn
            assign addr_next = {reg_address[AW-9:0], rx_next};
        end
    endgenerate

    assign busy = (state == ST_CMD)   || (state == ST_ADDR)  ||
                  (state == ST_WDATA) || (state == ST_RDATA) ||
                  (state == ST_IGNORE);

    // Frame state machine, shifters and all registered bus/pad outputs.
    always_ff @(posedge clock_sig) begin
        if (reset_sig) begin
            state         <= ST_IDLE;
            ss_prev       <= 1'b0;
            bit_cnt       <= 3'd0;
            rx_shift      <= 7'd0;
            tx_shift      <= 8'hFF;
            addr_cnt      <= 2'd0;
            is_read       <= 1'b0;
            load_pending  <= 1'b0;
            spi_miso      <= 1'b1;
            spi_miso_oe   <= 1'b0;
            reg_read      <= 1'b0;
            reg_write     <= 1'b0;
            reg_address   <= '0;
            reg_writedata <= 8'd0;
        end else begin
            ss_prev      <= ss_sync;
            spi_miso_oe  <= ~ss_sync;
            reg_write    <= 1'b0;
            reg_read     <= 1'b0;
            load_pending <= reg_read;

            if (reg_read || reg_write) begin
                reg_address <= reg_address + AW'(1);
            end

            if (load_pending) begin
                tx_shift <= reg_readdata;
            end

            if (ss_sync) begin
                state    <= ST_IDLE;
                bit_cnt  <= 3'd0;
                spi_miso <= 1'b1;
            end else begin
                if (rise) begin
                    rx_shift <= rx_next[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                end

                case (state)
                    ST_IDLE: begin
                        spi_miso <= 1'b1;
                        bit_cnt  <= 3'd0;
                        if (ss_prev) begin
                            state <= ST_CMD;
                        end else begin
                            state <= ST_WAIT_DESEL;
                        end
                    end

                    ST_CMD: begin
                        spi_miso <= 1'b1;
                        if (byte_done) begin
                            addr_cnt <= 2'd0;
                            is_read  <= (rx_next == 8'h03);
                            if ((rx_next == 8'h02) || (rx_next == 8'h03)) begin
                                state <= ST_ADDR;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end

                    ST_ADDR: begin
                        spi_miso <= 1'b1;
                        if (byte_done) begin
                            reg_address <= addr_next;
                            addr_cnt    <= addr_cnt + 2'd1;
                            if (addr_cnt == 2'(ADDR_BYTES - 1)) begin
                                if (is_read) begin
                                    state    <= ST_RDATA;
                                    reg_read <= 1'b1;
                                end else begin
                                    state <= ST_WDATA;
                                end
                            end
                        end
                    end

                    ST_WDATA: begin
                        spi_miso <= 1'b1;
                        if (byte_done) begin
                            reg_write     <= 1'b1;
                            reg_writedata <= rx_next;
                        end
                    end

                    ST_RDATA: begin
                        if (byte_done) begin
                            reg_read <= 1'b1;
                        end
                        if (fall) begin
                            spi_miso <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b1};
                        end
                    end

                    default: begin
                        spi_miso <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_air_spi_responder.sv
// Bench for air_spi_responder: an SPI host model drives directed frames at
// SCLK = clock/8, a transaction-level model predicts the bus strobes and the
// bytes the host must receive, and one process compares every cycle.
module tb_air_spi_responder;

    logic        clock_sig = 1'b0;
    logic        reset_sig;
    logic        spi_ss_n;
    logic        spi_ss2_n;
    logic        spi_sclk;
    logic        spi_mosi;

    logic        spi_miso, spi_miso_oe, reg_write, reg_read, busy;
    logic [7:0]  reg_address, reg_writedata, reg_readdata;

    logic        miso2, miso_oe2, reg_write2, reg_read2, busy2;
    logic [15:0] reg_address2;
    logic [7:0]  reg_writedata2;
    logic [7:0]  reg_readdata2 = 8'h00;

    int checks = 0;
    int errors = 0;

    logic [7:0] bank [256];
    logic [7:0] frame [16];
    logic [7:0] rx [16];
    logic [7:0] exp_miso [16];

    int exp_wr_addr[$], exp_wr_data[$], exp_rd_addr[$];
    int exp2_wr_addr[$], exp2_wr_data[$];
    int obs_wr_addr[$], obs_wr_data[$], obs_rd_addr[$];
    int obs2_wr_addr[$], obs2_wr_data[$];

    bit read_frame_active = 1'b0;
    bit prev_wr = 1'b0, prev_rd = 1'b0, prev_wr2 = 1'b0;

    always #5 clock_sig = ~clock_sig;

    air_spi_responder #(.ADDR_BYTES(1)) dut (
        .clock_sig     (clock_sig),
        .reset_sig     (reset_sig),
        .spi_ss_n      (spi_ss_n),
        .spi_sclk      (spi_sclk),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .spi_miso_oe   (spi_miso_oe),
        .reg_address   (reg_address),
        .reg_write     (reg_write),
        .reg_writedata (reg_writedata),
        .reg_read      (reg_read),
        .reg_readdata  (reg_readdata),
        .busy          (busy)
    );

    air_spi_responder #(.ADDR_BYTES(2)) dut2 (
        .clock_sig     (clock_sig),
        .reset_sig     (reset_sig),
        .spi_ss_n      (spi_ss2_n),
        .spi_sclk      (spi_sclk),
        .spi_mosi      (spi_mosi),
        .spi_miso      (miso2),
        .spi_miso_oe   (miso_oe2),
        .reg_address   (reg_address2),
        .reg_write     (reg_write2),
        .reg_writedata (reg_writedata2),
        .reg_read      (reg_read2),
        .reg_readdata  (reg_readdata2),
        .busy          (busy2)
    );

    // Register bank behind the first responder: data is presented the cycle after the read strobe.
    always @(posedge clock_sig) begin
        if (reg_read) reg_readdata <= bank[reg_address];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Predict strobes and received MISO bytes for the complete bytes of a frame.
    task automatic modelFrame(input int nbytes, input int abytes, input bit second, input bit killed);
        int addr;
        int mask;
        int ndata;
        for (int i = 0; i < 16; i++) exp_miso[i] = 8'hFF;
        if (killed || nbytes < 1 + abytes) return;
        addr = 0;
        for (int a = 0; a < abytes; a++) addr = (addr << 8) | int'(frame[1 + a]);
        mask  = (1 << (8 * abytes)) - 1;
        ndata = nbytes - 1 - abytes;
        if (frame[0] == 8'h02) begin
            for (int k = 0; k < ndata; k++) begin
                if (second) begin
                    exp2_wr_addr.push_back((addr + k) & mask);
                    exp2_wr_data.push_back(int'(frame[1 + abytes + k]));
                end else begin
                    exp_wr_addr.push_back((addr + k) & mask);
                    exp_wr_data.push_back(int'(frame[1 + abytes + k]));
                end
            end
        end else if (frame[0] == 8'h03) begin
            for (int k = 0; k <= ndata; k++) exp_rd_addr.push_back((addr + k) & mask);
            for (int k = 0; k < ndata; k++) exp_miso[1 + abytes + k] = bank[(addr + k) & mask & 255];
        end
    endtask

    task automatic clearObs();
        obs_wr_addr.delete(); obs_wr_data.delete(); obs_rd_addr.delete();
        obs2_wr_addr.delete(); obs2_wr_data.delete();
    endtask

    // SPI host: mode 0, MSB first, half period of 4 system clocks.
    task automatic applyStimulus(input int nbytes, input int extra_bits, input bit second,
                                 input int reset_bit, input bit exp_busy);
        logic [7:0] rxb;
        int total;
        rxb   = 8'h00;
        total = nbytes * 8 + extra_bits;
        @(negedge clock_sig);
        if (second) spi_ss2_n = 1'b0; else spi_ss_n = 1'b0;
        repeat (4) @(negedge clock_sig);
        for (int b = 0; b < total; b++) begin
            spi_mosi = frame[b / 8][7 - (b % 8)];
            repeat (4) @(negedge clock_sig);
            rxb = {rxb[6:0], (second ? miso2 : spi_miso)};
            spi_sclk = 1'b1;
            if (b == reset_bit) begin
                reset_sig = 1'b1;
                repeat (2) @(negedge clock_sig);
                reset_sig = 1'b0;
                repeat (2) @(negedge clock_sig);
            end else begin
                repeat (4) @(negedge clock_sig);
            end
            spi_sclk = 1'b0;
            if (b % 8 == 7) rx[b / 8] = rxb;
        end
        repeat (4) @(negedge clock_sig);
        checkOutput("busy_in_frame", second ? busy2 : busy, exp_busy);
        checkOutput("oe_in_frame", second ? miso_oe2 : spi_miso_oe, 1);
        spi_ss_n  = 1'b1;
        spi_ss2_n = 1'b1;
        repeat (3) @(posedge clock_sig);
        #1;
        checkOutput("busy_after_desel", second ? busy2 : busy, 0);
        checkOutput("oe_after_desel", second ? miso_oe2 : spi_miso_oe, 0);
        repeat (8) @(negedge clock_sig);
        for (int i = 0; i < nbytes; i++) checkOutput($sformatf("miso_byte%0d", i), rx[i], exp_miso[i]);
        checkOutput("wr_left", exp_wr_addr.size(), 0);
        checkOutput("rd_left", exp_rd_addr.size(), 0);
        checkOutput("wr2_left", exp2_wr_addr.size(), 0);
    endtask

    // Per-cycle comparison of both responders against the model queues.
    always @(negedge clock_sig) begin
        if (!reset_sig) begin
            checkOutput("rd_wr_overlap", reg_write & reg_read, 0);
            checkOutput("wr_strobe_len", reg_write & prev_wr, 0);
            checkOutput("rd_strobe_len", reg_read & prev_rd, 0);
            checkOutput("wr2_strobe_len", reg_write2 & prev_wr2, 0);
            checkOutput("rd2_none", reg_read2, 0);
            checkOutput("miso2_idle", miso2, 1);
            if (!read_frame_active) checkOutput("miso_idle", spi_miso, 1);
            if (reg_write) begin
                obs_wr_addr.push_back(int'(reg_address));
                obs_wr_data.push_back(int'(reg_writedata));
                checkOutput("wr_expected", exp_wr_addr.size() > 0, 1);
                if (exp_wr_addr.size() > 0) begin
                    checkOutput("wr_addr", reg_address, exp_wr_addr.pop_front());
                    checkOutput("wr_data", reg_writedata, exp_wr_data.pop_front());
                end
            end
            if (reg_read) begin
                obs_rd_addr.push_back(int'(reg_address));
                checkOutput("rd_expected", exp_rd_addr.size() > 0, 1);
                if (exp_rd_addr.size() > 0) checkOutput("rd_addr", reg_address, exp_rd_addr.pop_front());
            end
            if (reg_write2) begin
                obs2_wr_addr.push_back(int'(reg_address2));
                obs2_wr_data.push_back(int'(reg_writedata2));
                checkOutput("wr2_expected", exp2_wr_addr.size() > 0, 1);
                if (exp2_wr_addr.size() > 0) begin
                    checkOutput("wr2_addr", reg_address2, exp2_wr_addr.pop_front());
                    checkOutput("wr2_data", reg_writedata2, exp2_wr_data.pop_front());
                end
            end
        end
        prev_wr  = reg_write;
        prev_rd  = reg_read;
        prev_wr2 = reg_write2;
    end

    // Runaway guard.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        reg_readdata = 8'h00;
        for (int i = 0; i < 256; i++) bank[i] = 8'(i) ^ 8'hA5;
        bank[8'h20] = 8'h5A;
        bank[8'h21] = 8'hC3;
        reset_sig = 1'b1;
        spi_ss_n  = 1'b1;
        spi_ss2_n = 1'b1;
        spi_sclk  = 1'b0;
        spi_mosi  = 1'b0;
        repeat (6) @(negedge clock_sig);
        checkOutput("rst_miso", spi_miso, 1);
        checkOutput("rst_oe", spi_miso_oe, 0);
        checkOutput("rst_read", reg_read, 0);
        checkOutput("rst_write", reg_write, 0);
        checkOutput("rst_addr", reg_address, 0);
        checkOutput("rst_wdata", reg_writedata, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_addr2", reg_address2, 0);
        reset_sig = 1'b0;
        repeat (6) @(negedge clock_sig);

        // Write two bytes
        frame[0] = 8'h02; frame[1] = 8'h10; frame[2] = 8'hA5; frame[3] = 8'h3C;
        clearObs(); modelFrame(4, 1, 1'b0, 1'b0);
        applyStimulus(4, 0, 1'b0, -1, 1'b1);
        checkOutput("lit_wr_count", obs_wr_addr.size(), 2);
        if (obs_wr_addr.size() == 2) begin
            checkOutput("lit_wr0_addr", obs_wr_addr[0], 32'h10);
            checkOutput("lit_wr0_data", obs_wr_data[0], 32'hA5);
            checkOutput("lit_wr1_addr", obs_wr_addr[1], 32'h11);
            checkOutput("lit_wr1_data", obs_wr_data[1], 32'h3C);
        end

        // Read two bytes
        frame[0] = 8'h03; frame[1] = 8'h20; frame[2] = 8'h00; frame[3] = 8'h00;
        clearObs(); modelFrame(4, 1, 1'b0, 1'b0);
        read_frame_active = 1'b1;
        applyStimulus(4, 0, 1'b0, -1, 1'b1);
        read_frame_active = 1'b0;
        checkOutput("lit_rx0", rx[0], 32'hFF);
        checkOutput("lit_rx1", rx[1], 32'hFF);
        checkOutput("lit_rx2", rx[2], 32'h5A);
        checkOutput("lit_rx3", rx[3], 32'hC3);
        checkOutput("lit_rd_count", obs_rd_addr.size(), 3);
        if (obs_rd_addr.size() == 3) begin
            checkOutput("lit_rd0", obs_rd_addr[0], 32'h20);
            checkOutput("lit_rd1", obs_rd_addr[1], 32'h21);
            checkOutput("lit_rd2", obs_rd_addr[2], 32'h22);
        end

        // Address wrap, one address byte
        frame[0] = 8'h02; frame[1] = 8'hFF; frame[2] = 8'h11; frame[3] = 8'h22;
        clearObs(); modelFrame(4, 1, 1'b0, 1'b0);
        applyStimulus(4, 0, 1'b0, -1, 1'b1);
        checkOutput("lit_wrap_count", obs_wr_addr.size(), 2);
        if (obs_wr_addr.size() == 2) begin
            checkOutput("lit_wrap0", obs_wr_addr[0], 32'hFF);
            checkOutput("lit_wrap1", obs_wr_addr[1], 32'h00);
        end

        // Address wrap, two address bytes
        frame[0] = 8'h02; frame[1] = 8'hFF; frame[2] = 8'hFF; frame[3] = 8'h11; frame[4] = 8'h22;
        clearObs(); modelFrame(5, 2, 1'b1, 1'b0);
        applyStimulus(5, 0, 1'b1, -1, 1'b1);
        checkOutput("lit_wrap2_count", obs2_wr_addr.size(), 2);
        if (obs2_wr_addr.size() == 2) begin
            checkOutput("lit_wrap2_a0", obs2_wr_addr[0], 32'hFFFF);
            checkOutput("lit_wrap2_a1", obs2_wr_addr[1], 32'h0000);
            checkOutput("lit_wrap2_d1", obs2_wr_data[1], 32'h22);
        end

        // Abort after 5 bits of the second data byte
        frame[0] = 8'h02; frame[1] = 8'h30; frame[2] = 8'hAA; frame[3] = 8'hF0;
        clearObs(); modelFrame(3, 1, 1'b0, 1'b0);
        applyStimulus(3, 5, 1'b0, -1, 1'b1);
        checkOutput("lit_abort_count", obs_wr_addr.size(), 1);

        // Unknown command is ignored
        frame[0] = 8'h9F; frame[1] = 8'h01; frame[2] = 8'h02; frame[3] = 8'h03;
        clearObs(); modelFrame(4, 1, 1'b0, 1'b0);
        applyStimulus(4, 0, 1'b0, -1, 1'b1);
        checkOutput("lit_ign_wr", obs_wr_addr.size(), 0);
        checkOutput("lit_ign_rd", obs_rd_addr.size(), 0);

        // Reset during the address byte, remainder of the frame is ignored
        frame[0] = 8'h02; frame[1] = 8'h40; frame[2] = 8'h55; frame[3] = 8'h66;
        clearObs(); modelFrame(4, 1, 1'b0, 1'b1);
        applyStimulus(4, 0, 1'b0, 12, 1'b0);
        checkOutput("lit_rst_wr", obs_wr_addr.size(), 0);

        frame[0] = 8'h02; frame[1] = 8'h01; frame[2] = 8'h77;
        clearObs(); modelFrame(3, 1, 1'b0, 1'b0);
        applyStimulus(3, 0, 1'b0, -1, 1'b1);
        checkOutput("lit_post_rst_count", obs_wr_addr.size(), 1);
        if (obs_wr_addr.size() == 1) begin
            checkOutput("lit_post_rst_addr", obs_wr_addr[0], 32'h01);
            checkOutput("lit_post_rst_data", obs_wr_data[0], 32'h77);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/air_spi_responder.md
# air_spi_responder

SPI mode-0 responder (slave) that lets an external SPI host on the GPIO header `D` read and write an 8-bit-wide internal register bank. It complements the board's SPI initiator usage (EPCS, SD card): here PERIDOT-Air is the responder. All SPI inputs are oversampled in the system clock domain. The block sits between the GPIO pins and a simple synchronous register/bus slave port.

## Interface
- `ADDR_BYTES`, 1 — address bytes per frame (1 or 2); the register address width is 8*ADDR_BYTES.
- `clock_sig` in 1 — system clock; every flop is clocked on its rising edge.
- `reset_sig` in 1 — reset, synchronous and active-high.
- `spi_ss_n` in 1 — chip select, active low, asynchronous to `clock_sig`.
- `spi_sclk` in 1 — SPI clock, asynchronous; maximum frequency is clock_sig/8.
- `spi_mosi` in 1 — host to responder data, MSB first.
- `spi_miso` out 1 — responder to host data.
- `spi_miso_oe` out 1 — MISO pad output enable.
- `reg_address` out 8*ADDR_BYTES — register address.
- `reg_write` out 1 — one-cycle write strobe.
- `reg_writedata` out 8 — write data, valid while `reg_write`=1.
- `reg_read` out 1 — one-cycle read strobe.
- `reg_readdata` in 8 — read data, sampled exactly 1 cycle after `reg_read`.
- `busy` out 1 — 1 while a frame is in progress (state not IDLE/WAIT_DESEL).

## Operation
- **Input synchronisation:** 2-FF synchronisers on `spi_ss_n`, `spi_sclk` and `spi_mosi`, plus a third stage on `spi_sclk` for edge detection.
  - Rising SCLK (rise): shift synced MOSI into the receive shifter and increment the 3-bit bit counter.
  - Falling SCLK (fall): shift the transmit shifter, which drives `spi_miso` from its MSB.
- **Frame format:** command byte, then ADDR_BYTES address bytes (MSB byte first), then N data bytes.
- **Commands:** 0x02 = write, 0x03 = read. Any other command → IGNORE.
- **State machine:**
  - IDLE → CMD on synced ss_n falling.
  - CMD → ADDR on the 8th rise if the command is valid; otherwise → IGNORE.
  - ADDR → WDATA or RDATA after the last address byte.
  - WDATA/RDATA/IGNORE hold until ss_n rises.
  - Synced ss_n high in any state → IDLE within 1 cycle. The bit counter clears and any partial byte is discarded, with no strobe.
- **WDATA:**
  - On each completed byte: `reg_writedata` = byte, `reg_address` = current address, `reg_write`=1 for 1 cycle.
  - The address post-increments, wrapping modulo 2^(8*ADDR_BYTES).
- **RDATA:**
  - On completion of the last address byte, and on completion of every data byte: `reg_read`=1 for 1 cycle at the current address, then the address post-increments with wrap.
  - `reg_readdata` is loaded into the transmit shifter the next cycle. Its MSB appears on `spi_miso` at the following fall (the 8th fall of the byte just completed).
  - Bytes clocked in from MOSI during RDATA are ignored.
- **MISO value:**
  - `spi_miso_oe` = NOT synced ss_n.
  - `spi_miso` = 1 whenever it is not shifting read data (CMD, ADDR, IGNORE, IDLE).
- **Reset:**
  - Reset values: state IDLE; `spi_miso`=1, `spi_miso_oe`=0, `reg_read`=0, `reg_write`=0, `reg_address`=0, `reg_writedata`=0, `busy`=0.
  - If synced ss_n is low when reset releases, the state is WAIT_DESEL. It ignores the rest of that frame until ss_n goes high, then → IDLE.

## Timing
- Synchroniser latency: 2 cycles for ss_n and MOSI; edge detect on cycle 3 after the pin edge.
- Write strobe: asserted 1 cycle after the detected 8th rise of a data byte.
- Read path:
  - `reg_read` asserts 1 cycle after the detected 8th rise.
  - The readdata latch occurs 1 cycle later, so the transmit shifter is loaded 2 cycles after the detected rise.
  - At SCLK ≤ clock/8 the half-period is ≥4 cycles, so the load always precedes the detected 8th fall.
- `reg_read` and `reg_write` are never asserted in the same cycle.
- Strobes are never longer than 1 cycle.

## Test plan
- **Write:** frame 0x02, 0x10, 0xA5, 0x3C (SCLK = clock/8) → `reg_write` pulses with (addr 0x10, data 0xA5), then (0x11, 0x3C); exactly 2 pulses; MISO stays 1.
- **Read:** frame 0x03, 0x20, then 2 dummy bytes; the bank returns 0x5A @0x20 and 0xC3 @0x21 → `reg_read` pulses at 0x20, 0x21, 0x22; host receives 0xFF, 0xFF, 0x5A, 0xC3.
- **Wrap:** ADDR_BYTES=1; write 0x02, 0xFF, 0x11, 0x22 → writes land at 0xFF then 0x00. ADDR_BYTES=2 with address 0xFFFF behaves the same way (next address 0x0000).
- **Abort:** in a write frame, deassert ss_n after 5 bits of a data byte → no `reg_write` for that byte; state IDLE; `busy`=0 and `spi_miso_oe`=0 within 3 cycles.
- **Ignore:** command 0x9F followed by 3 bytes → no strobes, MISO=1 throughout, `busy`=1 until ss_n high.
- **Reset mid-frame:** assert `reset_sig` during the address byte of a write frame, and keep clocking bytes → no strobes until ss_n goes high; the next frame 0x02, 0x01, 0x77 writes 0x77 @0x01.
